// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: program counter, PC+4 adder, IF/ID pipeline register
// with stall/flush control, sticky misalignment flag and saturating event counters.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
   parameter int          CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      PC_in,
   input  logic             PC_write,
   input  logic             IF_ID_write,
   input  logic             IF_Flush,
   input  logic [31:0]      IF_instr,
   output logic [31:0]      PC,
   output logic [31:0]      IF_PC_plus4,
   output logic [31:0]      ID_PC_plus4,
   output logic [31:0]      ID_instr,
   output logic             ID_valid,
   output logic             PC_misalign,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic pc_load;
   logic stall_evt;

   // A flush redirects fetch even while the hazard unit is holding the PC.
   assign pc_load     = IF_Flush | PC_write;
   assign stall_evt   = ~IF_Flush & ~PC_write;
   assign IF_PC_plus4 = PC + 32'd4;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         PC          <= RESET_PC;
         PC_misalign <= 1'b0;
      end else if (pc_load) begin
         PC <= PC_in;
         if (PC_in[1:0] != 2'b00)
            PC_misalign <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ID_instr    <= NOP_INSTR;
         ID_PC_plus4 <= 32'd0;
         ID_valid    <= 1'b0;
      end else if (IF_Flush) begin
         ID_instr    <= NOP_INSTR;
         ID_PC_plus4 <= IF_PC_plus4;
         ID_valid    <= 1'b0;
      end else if (IF_ID_write) begin
         ID_instr    <= IF_instr;
         ID_PC_plus4 <= IF_PC_plus4;
         ID_valid    <= 1'b1;
      end
   end

   // Debug counters stick at all-ones rather than wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_evt && (stall_cnt != CNT_MAX))
            stall_cnt <= stall_cnt + CNT_ONE;
         if (IF_Flush && (flush_cnt != CNT_MAX))
            flush_cnt <= flush_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: boot, stall, flush, flush-in-stall,
// misalign/wrap, asynchronous reset and counter saturation on a narrow instance.
module tb_if_fetch_stage;

   logic        clk;
   logic        rst_n;
   logic [31:0] PC_in;
   logic        PC_write;
   logic        IF_ID_write;
   logic        IF_Flush;
   logic [31:0] IF_instr;
   logic [31:0] PC;
   logic [31:0] IF_PC_plus4;
   logic [31:0] ID_PC_plus4;
   logic [31:0] ID_instr;
   logic        ID_valid;
   logic        PC_misalign;
   logic [15:0] stall_cnt;
   logic [15:0] flush_cnt;

   logic [31:0] s_pc, s_if_pc_plus4, s_id_pc_plus4, s_id_instr;
   logic        s_id_valid, s_pc_misalign;
   logic [1:0]  s_stall_cnt, s_flush_cnt;

   logic        follow;
   logic        use_fixed;
   logic [31:0] pc_in_drv;

   int total;
   int bad;

   // PC_in either follows the sequential path or is forced; memory returns a fixed
   // word during boot, otherwise a word derived from the fetch address.
   assign PC_in    = follow ? IF_PC_plus4 : pc_in_drv;
   assign IF_instr = use_fixed ? 32'h2008_0005 : (32'hA000_0000 ^ PC);

   if_fetch_stage dut (
      .clk(clk), .rst_n(rst_n), .PC_in(PC_in), .PC_write(PC_write),
      .IF_ID_write(IF_ID_write), .IF_Flush(IF_Flush), .IF_instr(IF_instr),
      .PC(PC), .IF_PC_plus4(IF_PC_plus4), .ID_PC_plus4(ID_PC_plus4),
      .ID_instr(ID_instr), .ID_valid(ID_valid), .PC_misalign(PC_misalign),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   if_fetch_stage #(.CNT_W(2)) dut_s (
      .clk(clk), .rst_n(rst_n), .PC_in(PC_in), .PC_write(PC_write),
      .IF_ID_write(IF_ID_write), .IF_Flush(IF_Flush), .IF_instr(IF_instr),
      .PC(s_pc), .IF_PC_plus4(s_if_pc_plus4), .ID_PC_plus4(s_id_pc_plus4),
      .ID_instr(s_id_instr), .ID_valid(s_id_valid), .PC_misalign(s_pc_misalign),
      .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n       = 1'b0;
      PC_write    = 1'b1;
      IF_ID_write = 1'b1;
      IF_Flush    = 1'b0;
      follow      = 1'b1;
      use_fixed   = 1'b1;
      pc_in_drv   = 32'h0;

      // Reset state
      #3;
      chk("rst_pc", PC, 32'h0);
      chk("rst_id_instr", ID_instr, 32'h0);
      chk("rst_id_pc4", ID_PC_plus4, 32'h0);
      chk("rst_id_valid", {31'b0, ID_valid}, 32'h0);
      chk("rst_misalign", {31'b0, PC_misalign}, 32'h0);
      chk("rst_stall", {16'b0, stall_cnt}, 32'h0);
      chk("rst_flush", {16'b0, flush_cnt}, 32'h0);
      chk("rst_pc4", IF_PC_plus4, 32'h4);
      @(posedge clk);
      #1;
      chk("rst_hold_pc", PC, 32'h0);
      #1 rst_n = 1'b1;

      // Boot
      step();
      chk("boot1_pc", PC, 32'h4);
      chk("boot1_instr", ID_instr, 32'h2008_0005);
      chk("boot1_pc4", ID_PC_plus4, 32'h4);
      chk("boot1_valid", {31'b0, ID_valid}, 32'h1);
      step();
      chk("boot2_pc", PC, 32'h8);
      chk("boot2_pc4", ID_PC_plus4, 32'h8);

      // Load-use stall at PC=8
      use_fixed   = 1'b0;
      PC_write    = 1'b0;
      IF_ID_write = 1'b0;
      step();
      chk("stall_pc", PC, 32'h8);
      chk("stall_instr", ID_instr, 32'h2008_0005);
      chk("stall_pc4", ID_PC_plus4, 32'h8);
      chk("stall_cnt1", {16'b0, stall_cnt}, 32'h1);
      PC_write    = 1'b1;
      IF_ID_write = 1'b1;
      step();
      chk("resume_pc", PC, 32'hC);
      chk("resume_instr", ID_instr, 32'hA000_0008);
      chk("resume_pc4", ID_PC_plus4, 32'hC);
      step();
      chk("seq_pc", PC, 32'h10);

      // Branch flush at PC=16
      IF_Flush  = 1'b1;
      follow    = 1'b0;
      pc_in_drv = 32'h40;
      step();
      chk("flush_pc", PC, 32'h40);
      chk("flush_instr", ID_instr, 32'h0);
      chk("flush_valid", {31'b0, ID_valid}, 32'h0);
      chk("flush_pc4", ID_PC_plus4, 32'h14);
      chk("flush_cnt1", {16'b0, flush_cnt}, 32'h1);
      chk("flush_stall_cnt", {16'b0, stall_cnt}, 32'h1);
      IF_Flush = 1'b0;
      follow   = 1'b1;
      step();
      chk("tgt_pc", PC, 32'h44);
      chk("tgt_instr", ID_instr, 32'hA000_0040);
      chk("tgt_pc4", ID_PC_plus4, 32'h44);
      chk("tgt_valid", {31'b0, ID_valid}, 32'h1);

      // Flush during stall
      IF_Flush    = 1'b1;
      PC_write    = 1'b0;
      IF_ID_write = 1'b0;
      follow      = 1'b0;
      pc_in_drv   = 32'h100;
      step();
      chk("fs_pc", PC, 32'h100);
      chk("fs_valid", {31'b0, ID_valid}, 32'h0);
      chk("fs_pc4", ID_PC_plus4, 32'h48);
      chk("fs_flush_cnt", {16'b0, flush_cnt}, 32'h2);
      chk("fs_stall_cnt", {16'b0, stall_cnt}, 32'h1);
      IF_Flush    = 1'b0;
      PC_write    = 1'b1;
      IF_ID_write = 1'b1;

      // Misaligned load, then wrap of PC+4
      pc_in_drv = 32'h42;
      step();
      chk("mis_pc", PC, 32'h42);
      chk("mis_flag", {31'b0, PC_misalign}, 32'h1);
      pc_in_drv = 32'hFFFF_FFFC;
      step();
      chk("wrap_pc", PC, 32'hFFFF_FFFC);
      chk("mis_sticky", {31'b0, PC_misalign}, 32'h1);
      chk("wrap_pc4", IF_PC_plus4, 32'h0);
      chk("mis_id_pc4", ID_PC_plus4, 32'h46);
      follow = 1'b1;
      step();
      chk("wrap_next_pc", PC, 32'h0);
      chk("wrap_id_pc4", ID_PC_plus4, 32'h0);
      chk("wrap_id_instr", ID_instr, 32'h5FFF_FFFC);

      // Asynchronous reset in the middle of a stall at PC=0x40
      follow    = 1'b0;
      pc_in_drv = 32'h40;
      step();
      chk("pre_ar_pc", PC, 32'h40);
      PC_write    = 1'b0;
      IF_ID_write = 1'b0;
      step();
      chk("pre_ar_stall", {16'b0, stall_cnt}, 32'h2);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_pc", PC, 32'h0);
      chk("ar_valid", {31'b0, ID_valid}, 32'h0);
      chk("ar_stall", {16'b0, stall_cnt}, 32'h0);
      chk("ar_flush", {16'b0, flush_cnt}, 32'h0);
      chk("ar_misalign", {31'b0, PC_misalign}, 32'h0);
      chk("ar_instr", ID_instr, 32'h0);
      PC_write    = 1'b1;
      IF_ID_write = 1'b1;
      follow      = 1'b1;
      #2 rst_n = 1'b1;
      step();
      chk("post_ar_pc", PC, 32'h4);
      chk("post_ar_instr", ID_instr, 32'hA000_0000);

      // Counter saturation: narrow instance stops at 3
      IF_Flush = 1'b1;
      for (int i = 0; i < 5; i++) step();
      chk("sat_flush_wide", {16'b0, flush_cnt}, 32'h5);
      chk("sat_flush_narrow", {30'b0, s_flush_cnt}, 32'h3);
      IF_Flush = 1'b0;
      PC_write = 1'b0;
      for (int i = 0; i < 5; i++) step();
      chk("sat_stall_wide", {16'b0, stall_cnt}, 32'h5);
      chk("sat_stall_narrow", {30'b0, s_stall_cnt}, 32'h3);
      chk("sat_flush_hold", {30'b0, s_flush_cnt}, 32'h3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
